seven_segment_tick_counter: RTL and testbench
=============================================

Name: seven_segment_tick_counter

Overview:
Upstream feeder for the seven-segment seconds display. It divides the user-project clock into a programmable "second" tick and keeps a BCD digit count from 0 to 9. It presents that digit, with a one-cycle valid strobe, to the segment decoder that drives mprj_io[14:8]. The tick period and the run/clear controls are programmable from the management SoC over the Wishbone slave port, so simulation can use short periods.

Parameters:
COMPARE_WIDTH, 24, width of the prescaler counter and of the COMPARE register.
DEFAULT_COMPARE, 24'd1000, COMPARE value loaded at reset.
BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes a 256-byte window.

Ports:
wb_clk_i  in  1  single clock; every flop is on its rising edge.
wb_rst_i  in  1  synchronous, active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  Wishbone write enable.
wbs_sel_i  in  4  byte enables.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
tick_o  out  1  one-cycle pulse at each prescaler wrap.
digit_o  out  4  current BCD digit, 0 to 9.
digit_valid_o  out  1  one-cycle pulse in the cycle digit_o takes a new value.

Behaviour:
- Reset values (synchronous, wb_rst_i=1 at a clock edge):
  - cnt=0, digit_o=0, tick_o=0, digit_valid_o=0.
  - COMPARE=DEFAULT_COMPARE, CTRL.enable=1.
  - wbs_ack_o=0, wbs_dat_o=0.
  - Reset asserted mid-transaction drops ack and aborts the access; no register is written.
- Register map (offset = wbs_adr_i[7:0]; hit = cyc & stb & wbs_adr_i[31:8]==BASE_ADDR[31:8]):
  - 0x00 COMPARE, RW, bits [COMPARE_WIDTH-1:0]; upper bits read 0. wbs_sel_i honoured per byte.
  - 0x04 CTRL, RW. Bit0 enable. Bit1 clear: write-1, self-clearing, always reads 0.
  - 0x08 STATUS, RO. [3:0] digit_o, [4] enable, [31:5]=0.
  - Any other offset in the window: acked, reads 0, writes ignored.
- Wishbone handshake:
  - On a hit with wbs_ack_o=0, the write or read is performed and wbs_ack_o=1 on the next edge. It is held exactly one cycle, then 0.
  - Back-to-back strobes are therefore acked every other cycle.
  - wbs_dat_o is valid in the ack cycle and 0 otherwise.
  - No ack for addresses outside the window.
- Prescaler:
  - Advances only while enable=1.
  - Effective limit L = max(COMPARE,1).
  - If cnt >= L-1, the next edge sets cnt=0 and tick_o=1 (registered, lasts one cycle). Otherwise cnt=cnt+1 and tick_o=0.
  - Consequences: the tick period is L cycles, COMPARE=0 or 1 ticks every cycle, and lowering COMPARE below the current cnt causes a wrap plus tick on the next edge.
  - enable=0 freezes cnt and digit and holds tick_o=0. Re-enabling resumes from the frozen cnt.
- Digit counter:
  - The increment is taken in the same edge that asserts tick_o. Digit 9 wraps to 0; all other values increment by 1.
  - digit_valid_o equals tick_o: both are asserted in the cycle digit_o shows the new value.
- Clear:
  - Writing CTRL with bit1=1 forces cnt=0 and digit_o=0 on the next edge, and suppresses tick_o and digit_valid_o in that cycle.
  - Clear beats a simultaneous wrap.
  - Bit0 in the same write updates enable as normal.
- COMPARE write takes effect from the edge after the ack cycle's write.

Test Plan:
- Reset with defaults, held 3000 cycles: tick_o pulses exactly at cycles 1000, 2000 and 3000 after reset release; digit_o steps 0→1→2→3; digit_valid_o coincides with tick_o each time.
- Write COMPARE=4 (sel=4'hF) → ack exactly one cycle after stb. Within 40 cycles digit_o runs 0..9 then wraps to 0, with ticks spaced 4 cycles apart. Read 0x08 → [3:0] matches digit_o.
- COMPARE=10, wait until cnt=7, write COMPARE=3 → tick on the next edge, then a tick every 3 cycles. COMPARE=0 → tick_o stays high continuously and digit increments every cycle.
- Write CTRL=0 at digit 5 → digit_o and tick_o frozen for 100 cycles, STATUS=0x05. Write CTRL=0x3 → digit 0 on the next edge, counting resumes, and CTRL reads back 0x1.
- Clear issued in the same cycle as a prescaler wrap → digit_o=0, no tick_o or digit_valid_o pulse. Access to 0x0C → ack, read 0. Access to 0x3000_0100 → no ack.
- Assert wb_rst_i during an ack cycle and mid-count → all outputs 0 next edge; COMPARE reads back 1000 and CTRL reads back 0x1.

Source files
------------

// File: rtl/seven_segment_tick_counter.sv
// Prescaled "seconds" tick plus a BCD 0-9 digit counter feeding the seven-segment decoder.
// Tick period and run/clear controls sit behind a small Wishbone slave register window.
module seven_segment_tick_counter #(
  parameter int unsigned              COMPARE_WIDTH   = 24,
  parameter logic [COMPARE_WIDTH-1:0] DEFAULT_COMPARE = 24'd1000,
  parameter logic [31:0]              BASE_ADDR       = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        tick_o,
  output logic [3:0]  digit_o,
  output logic        digit_valid_o
);

  localparam logic [7:0] OffCompare = 8'h00;
  localparam logic [7:0] OffCtrl    = 8'h04;
  localparam logic [7:0] OffStatus  = 8'h08;

  logic [COMPARE_WIDTH-1:0] cnt_q, cnt_d;
  logic [COMPARE_WIDTH-1:0] compare_q, compare_d;
  logic [COMPARE_WIDTH-1:0] limit_m1;
  logic [3:0]               digit_q, digit_d;
  logic                     tick_q, tick_d;
  logic                     enable_q, enable_d;
  logic                     ack_q, ack_d;
  logic [31:0]              dat_q, dat_d;
  logic [31:0]              rdata;
  logic [31:0]              byte_mask;
  logic [7:0]               offset;
  logic                     hit, access, wr, clear;

  assign offset    = wbs_adr_i[7:0];
  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A new access is only taken while no ack is outstanding, giving one ack per two cycles.
  assign access    = hit & ~ack_q;
  assign wr        = access & wbs_we_i;
  assign clear     = wr & (offset == OffCtrl) & wbs_sel_i[0] & wbs_dat_i[1];
  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  always_comb begin
    rdata = '0;
    case (offset)
      OffCompare: rdata = 32'(compare_q);
      OffCtrl:    rdata = {31'b0, enable_q};
      OffStatus:  rdata = {27'b0, enable_q, digit_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    compare_d = compare_q;
    enable_d  = enable_q;
    if (wr && offset == OffCompare) begin
      compare_d = (compare_q & ~byte_mask[COMPARE_WIDTH-1:0])
                | (wbs_dat_i[COMPARE_WIDTH-1:0] & byte_mask[COMPARE_WIDTH-1:0]);
    end
    if (wr && offset == OffCtrl && wbs_sel_i[0]) begin
      enable_d = wbs_dat_i[0];
    end
  end

  always_comb begin
    ack_d = access;
    dat_d = (access && !wbs_we_i) ? rdata : '0;
  end

  // COMPARE of 0 behaves like 1, so the wrap threshold never underflows.
  assign limit_m1 = (compare_q == '0) ? '0 : compare_q - COMPARE_WIDTH'(1);

  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    tick_d  = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (enable_q) begin
      if (cnt_q >= limit_m1) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      end else begin
        cnt_d = cnt_q + COMPARE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      digit_q   <= '0;
      tick_q    <= 1'b0;
      compare_q <= DEFAULT_COMPARE;
      enable_q  <= 1'b1;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      tick_q    <= tick_d;
      compare_q <= compare_d;
      enable_q  <= enable_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign tick_o        = tick_q;
  assign digit_o       = digit_q;
  assign digit_valid_o = tick_q;

endmodule

// File: tb/tb_seven_segment_tick_counter.sv
// Directed plus randomized bench for seven_segment_tick_counter against a cycle-level
// behavioural model of the register window, prescaler and BCD digit.
module tb_seven_segment_tick_counter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack, tick, valid;
  logic [31:0] dat;
  logic [3:0]  digit;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          m_cnt, m_cmp, m_digit;
  bit          m_tick, m_en, m_ack;
  logic [31:0] m_dat;

  // Observations captured in the ack cycle of the last access
  logic [3:0]  a_digit;
  logic        a_tick, a_valid;
  int          a_lat;

  seven_segment_tick_counter dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat),
    .tick_o        (tick),
    .digit_o       (digit),
    .digit_valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return 32'(m_cmp);
      8'h04:   return m_en ? 32'd1 : 32'd0;
      8'h08:   return (m_en ? 32'h10 : 32'h0) | 32'(m_digit);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: advance the model from the driven inputs, then compare every output.
  task automatic step();
    int n_cnt, n_cmp, n_digit, lim;
    bit n_tick, n_en, n_ack, acc, clr;
    logic [31:0] n_dat, mask;
    if (rst) begin
      n_cnt = 0; n_digit = 0; n_tick = 0; n_en = 1; n_cmp = 1000; n_ack = 0; n_dat = 0;
    end else begin
      acc   = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
      n_ack = acc;
      n_dat = (acc && !we) ? m_read(adr[7:0]) : 32'h0;
      n_en  = m_en;
      n_cmp = m_cmp;
      clr   = 0;
      if (acc && we && adr[7:0] == 8'h00) begin
        for (int b = 0; b < 3; b++) begin
          if (sel[b]) begin
            mask  = 32'hFF << (8 * b);
            n_cmp = int'((32'(n_cmp) & ~mask) | (wdat & mask));
          end
        end
      end
      if (acc && we && adr[7:0] == 8'h04 && sel[0]) begin
        n_en = wdat[0];
        clr  = wdat[1];
      end
      lim     = (m_cmp < 1) ? 1 : m_cmp;
      n_tick  = 0;
      n_cnt   = m_cnt;
      n_digit = m_digit;
      if (clr) begin
        n_cnt = 0; n_digit = 0;
      end else if (m_en) begin
        if (m_cnt >= lim - 1) begin
          n_cnt = 0; n_tick = 1; n_digit = (m_digit + 1) % 10;
        end else begin
          n_cnt = m_cnt + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_cmp = n_cmp; m_digit = n_digit; m_tick = n_tick;
    m_en = n_en; m_ack = n_ack; m_dat = n_dat;
    check("cycle", 64'({ack, dat, tick, digit, valid}),
          64'({m_ack, m_dat, m_tick, 4'(m_digit), m_tick}));
  endtask

  task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit hold,
                           output bit got, output logic [31:0] rd);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    got = 0; rd = 0; a_lat = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (ack === 1'b1) begin
        got = 1; rd = dat; a_digit = digit; a_tick = tick; a_valid = valid; a_lat = k + 1;
      end
    end
    if (got && hold) step();
    cyc = 0; stb = 0; we = 0;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit got;
    logic [31:0] rd;
    wb_access(1, a, d, 4'hF, 0, got, rd);
    check("write_ack", 64'(got), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bit got;
    logic [31:0] rd;
    wb_access(0, a, 32'h0, 4'hF, 0, got, rd);
    check({tag, "_ack"}, 64'(got), 64'd1);
    check(tag, 64'(rd), 64'(exp));
  endtask

  initial begin
    bit          got, frozen, wrap_seen, w, hold, exp_hit;
    logic [31:0] rdv, a, d, expv;
    logic [3:0]  s;
    int          tick_pos[$];
    int          nt, last;

    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    m_cnt = 0; m_cmp = 1000; m_digit = 0; m_tick = 0; m_en = 1; m_ack = 0; m_dat = 0;
    step();
    step();
    check("reset_outputs", 64'({ack, dat, tick, digit, valid}), 64'd0);

    // Default period: ticks at 1000, 2000, 3000 cycles after release.
    rst = 0;
    for (int i = 1; i <= 3000; i++) begin
      step();
      if (tick === 1'b1) tick_pos.push_back(i);
    end
    check("default_tick_count", 64'(tick_pos.size()), 64'd3);
    if (tick_pos.size() == 3) begin
      check("tick_at_1000", 64'(tick_pos[0]), 64'd1000);
      check("tick_at_2000", 64'(tick_pos[1]), 64'd2000);
      check("tick_at_3000", 64'(tick_pos[2]), 64'd3000);
    end
    check("digit_after_3000", 64'(digit), 64'd3);

    // COMPARE=4: one-cycle ack latency, ten ticks four cycles apart, digit wraps.
    wb_access(1, BASE, 32'd4, 4'hF, 0, got, rdv);
    check("cmp4_ack", 64'(got), 64'd1);
    check("cmp4_ack_latency", 64'(a_lat), 64'd1);
    nt = 0; last = -1; wrap_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick === 1'b1) begin
        if (last >= 0) check("tick_spacing4", 64'(i - last), 64'd4);
        if (digit === 4'd0) wrap_seen = 1;
        last = i; nt++;
      end
    end
    check("cmp4_ticks", 64'(nt), 64'd10);
    check("cmp4_wrap", 64'(wrap_seen), 64'd1);
    expv = m_read(8'h08);
    rd_chk("status_digit", BASE + 32'h8, expv);

    // Lowering COMPARE below the running count forces an immediate wrap.
    wr(BASE, 32'd10);
    for (int k = 0; k < 20 && m_cnt != 7; k++) step();
    wr(BASE, 32'd3);
    check("lower_cmp_tick", 64'(tick), 64'd1);
    step(); step(); step();
    check("cmp3_period", 64'(tick), 64'd1);
    wr(BASE, 32'd0);
    nt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tick === 1'b1) nt++;
    end
    check("cmp0_continuous", 64'(nt), 64'd5);

    // Disable at digit 5, stay frozen, then clear+enable.
    for (int k = 0; k < 20 && m_digit != 4; k++) step();
    wr(BASE + 32'h4, 32'h0);
    frozen = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (digit !== 4'd5 || tick !== 1'b0) frozen = 0;
    end
    check("frozen_100", 64'(frozen), 64'd1);
    rd_chk("status_frozen", BASE + 32'h8, 32'h5);
    wr(BASE + 32'h4, 32'h3);
    check("clear_digit", 64'(a_digit), 64'd0);
    check("clear_no_valid", 64'(a_valid), 64'd0);
    rd_chk("ctrl_readback", BASE + 32'h4, 32'h1);

    // Clear coinciding with a wrap wins.
    wr(BASE, 32'd4);
    for (int k = 0; k < 50 && !(m_cnt == 3 && m_digit != 0); k++) step();
    wr(BASE + 32'h4, 32'h3);
    check("clr_wrap_digit", 64'(a_digit), 64'd0);
    check("clr_wrap_tick", 64'(a_tick), 64'd0);
    check("clr_wrap_valid", 64'(a_valid), 64'd0);

    rd_chk("unmapped_read", BASE + 32'hC, 32'h0);
    wb_access(1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 0, got, rdv);
    check("unmapped_write_ack", 64'(got), 64'd1);
    rd_chk("cmp_after_unmapped", BASE, 32'd4);
    wb_access(0, 32'h3000_0100, 32'h0, 4'hF, 0, got, rdv);
    check("outside_no_ack", 64'(got), 64'd0);

    // Randomized bus traffic; the model checks every cycle.
    for (int it = 0; it < 250; it++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
      case ($urandom_range(0, 5))
        0:       a = BASE;
        1:       a = BASE + 32'h4;
        2:       a = BASE + 32'h8;
        3:       a = BASE + 32'hC;
        4:       a = BASE | 32'($urandom_range(0, 63) << 2);
        default: a = $urandom;
      endcase
      w = 1'($urandom_range(0, 1));
      if (a[7:0] == 8'h04) d = {30'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      else d = 32'($urandom_range(0, 9)) | ($urandom & 32'hFF00_0000);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      hold = ($urandom_range(0, 3) == 0);
      exp_hit = (a[31:8] == BASE[31:8]);
      expv = m_read(a[7:0]);
      wb_access(w, a, d, s, hold, got, rdv);
      check("rand_ack", 64'(got), 64'(exp_hit));
      if (!w && exp_hit) check("rand_read", 64'(rdv), 64'(expv));
    end

    // Reset during an ack cycle, mid-count.
    wr(BASE + 32'h4, 32'h1);
    wr(BASE, 32'd50);
    for (int i = 0; i < 10; i++) step();
    cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'd7; sel = 4'hF;
    step();
    check("pre_reset_ack", 64'(ack), 64'd1);
    rst = 1;
    step();
    check("reset_in_ack", 64'({ack, dat, tick, digit, valid}), 64'd0);
    rst = 0; cyc = 0; stb = 0; we = 0;
    step();
    for (int i = 0; i < 5; i++) step();
    rst = 1; cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'd9;
    step();
    check("reset_abort_ack", 64'(ack), 64'd0);
    rst = 0; cyc = 0; stb = 0; we = 0;
    step();
    rd_chk("cmp_default", BASE, 32'd1000);
    rd_chk("ctrl_default", BASE + 32'h4, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
